codifica_hamming_serial: RTL
============================

Name: codifica_hamming_serial

Overview:
Hamming(15,11) transmit stage that sits directly upstream of the team's combinational Hamming corrector.
- Accepts 11-bit data words on a valid/ready handshake.
- Encodes each word into a 15-bit codeword and can inject a single-bit error for test.
- Serialises the codeword one bit per clock, framed by start/end markers.
- Also presents the parallel codeword, so the corrector can be driven directly in loopback.

Parameters:
GAP, 0, idle cycles inserted between consecutive frames (0 = back-to-back).
MSB_FIRST, 0, 0 = transmit c[0] first; 1 = transmit c[14] first.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  in_data/in_err_pos are valid.
in_ready  output  1  block can accept a word.
in_data  input  11  payload d[10:0].
in_err_pos  input  4  0 = no injection; 1..15 = flip codeword position p (bit c[p-1]).
tx_bit  output  1  serial codeword bit.
tx_valid  output  1  tx_bit is meaningful.
tx_sof  output  1  first bit of frame.
tx_eof  output  1  last bit of frame.
cw_out  output  15  codeword of the frame currently or last transmitted.
busy  output  1  buffer full or frame/gap in progress.

Behaviour:
- Reset (async, rst_n=0): all outputs 0, including in_ready. FSM goes to IDLE, buffer is empty, bit counter is 0. An in-flight frame is aborted and tx_valid drops immediately. After release, in_ready goes to 1 on the first clock edge.
- Codeword map, index i = position i+1:
  - Data bits: c[2]=d0, c[4]=d1, c[5]=d2, c[6]=d3, c[8..14]=d4..d10.
  - Parity bits: c[0]=^{c2,c4,c6,c8,c10,c12,c14}; c[1]=^{c2,c5,c6,c9,c10,c13,c14}; c[3]=^{c4,c5,c6,c11,c12,c13,c14}; c[7]=^{c8..c14}.
  - Injection: after parity, if in_err_pos != 0, invert c[in_err_pos-1].
- Encoding is combinational on the inputs. The encoded word is registered into a 1-entry holding buffer on accept.
- Accept rule: in_ready = !buf_full, with no combinational path from the output side. Accept happens when in_valid && in_ready at a clock edge.
- Shifter: 15-bit shift register plus a 4-bit counter (0..14).
- FSM states:
  - IDLE: tx_valid=0. If buf_full, load the shifter and cw_out, clear the buffer, counter=0, go to SHIFT.
  - SHIFT: tx_valid=1. tx_bit is c[cnt] (or c[14-cnt] when MSB_FIRST). tx_sof=(cnt==0). tx_eof=(cnt==14). The counter increments each cycle.
    - At cnt==14 with GAP>0: go to GAP.
    - At cnt==14 with GAP==0: if buf_full, reload the shifter, cw_out and counter on the same edge and stay in SHIFT. Otherwise go to IDLE.
  - GAP: tx_valid=0 for exactly GAP cycles, then behave as IDLE.
- Latency: word accepted at edge k, buffer full after k. With the shifter idle, it loads at edge k+1, so tx_sof/first bit is visible after edge k+1.
- Throughput with GAP=0: continuous tx_valid, one frame per 15 cycles, provided the next word arrives before the eof edge.
- Simultaneous events: a buffer drain and a new accept on the same edge is not possible, because in_ready is low while full. The buffer frees at the load edge and in_ready rises after it.
- Between frames, cw_out holds its value. tx_sof and tx_eof are never asserted with tx_valid=0.
- Inputs are ignored while in_ready=0; in_data may change freely.

Decomposition:
- Shared package hamming_pkg holds:
  - constants for data width (11), codeword width (15) and parity count (4);
  - the data-to-position index table;
  - a function encode_hamming(d) returning the 15-bit codeword.
  - The corrector stage reuses the same package, so the bit mapping has a single definition.
- One sub-module: hamming_encode, purely combinational (data and err_pos in, codeword out). The top level holds the buffer, FSM and shifter.

Test Plan:
- Encode known words:
  - in_data=11'h000 -> cw_out=15'h0000, and 15 tx_bits are all 0 with sof on bit 0 and eof on bit 14.
  - 11'h7FF -> 15'h7FFF.
  - 11'h001 -> 15'h0007, serial LSB-first 1,1,1,0,...
- Injection: in_data=11'h001, in_err_pos=3 -> cw_out=15'h0003. Feeding cw_out to the downstream corrector returns 11'h001. Repeat for all 16 err_pos values and random data: corrected output always equals in_data.
- Back-to-back: GAP=0, words A,B,C presented with in_valid held high -> tx_valid continuous for 45 cycles. in_ready shows one accept per frame. sof occurs every 15 cycles.
- Back-pressure and gap: GAP=2, two words -> exactly 2 tx_valid=0 cycles between eof and the next sof. in_valid held with in_ready=0 causes no duplicate or lost word.
- Reset mid-frame: assert rst_n=0 at cnt=7 -> outputs zero immediately. After release, the next word transmits a complete fresh frame from sof.
- MSB_FIRST=1 with 11'h001 -> serial 0,...,0,1,1,1 with eof on the last 1.

Source files
------------

// File: rtl/hamming_pkg.sv
// Shared Hamming(15,11) definitions: widths, data-bit placement and the
// reference encoder. The downstream corrector imports this same package so
// the bit mapping is defined in exactly one place.
package hamming_pkg;

    localparam int DATA_W = 11;
    localparam int CW_W   = 15;
    localparam int PAR_W  = 4;
    localparam int POS_W  = 4;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [CW_W-1:0]   cw_t;
    typedef logic [POS_W-1:0]  pos_t;

    // Codeword index (position-1) that carries data bit k.
    localparam int unsigned DATA_POS [0:DATA_W-1] = '{2, 4, 5, 6, 8, 9, 10, 11, 12, 13, 14};

    // Transmit FSM states, also visible on the debug state output.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } tx_state_t;

    // Place data bits, then fill the four parity bits (even parity).
    function automatic cw_t encode_hamming(input data_t d);
        cw_t c;
        c = '0;
        for (int k = 0; k < DATA_W; k++) begin
            c[DATA_POS[k]] = d[k];
        end
        c[0] = ^{c[2], c[4], c[6], c[8], c[10], c[12], c[14]};
        c[1] = ^{c[2], c[5], c[6], c[9], c[10], c[13], c[14]};
        c[3] = ^{c[4], c[5], c[6], c[11], c[12], c[13], c[14]};
        c[7] = ^{c[8], c[9], c[10], c[11], c[12], c[13], c[14]};
        return c;
    endfunction

endpackage

// File: rtl/codifica_hamming_serial_if.sv
// Bundle of the word-input handshake and the serial/parallel transmit side.
//
// Handshake: a word transfers on a rising clk edge where in_valid && in_ready
// are both high. in_ready is a pure register output (no combinational path
// from in_valid or from the transmit side); in_data/in_err_pos are only looked
// at on a transfer edge and may change freely otherwise. The transmit side has
// no back-pressure: tx_bit/tx_sof/tx_eof mean something only while tx_valid=1.
interface codifica_hamming_serial_if;
    import hamming_pkg::*;

    logic      in_valid;
    logic      in_ready;
    data_t     in_data;
    pos_t      in_err_pos;
    logic      tx_bit;
    logic      tx_valid;
    logic      tx_sof;
    logic      tx_eof;
    cw_t       cw_out;
    logic      busy;
    tx_state_t dbg_state;

    modport slave (
        input  in_valid, in_data, in_err_pos,
        output in_ready, tx_bit, tx_valid, tx_sof, tx_eof, cw_out, busy, dbg_state
    );

    modport master (
        output in_valid, in_data, in_err_pos,
        input  in_ready, tx_bit, tx_valid, tx_sof, tx_eof, cw_out, busy, dbg_state
    );

endinterface

// File: rtl/hamming_encode.sv
// Combinational Hamming(15,11) encoder with optional single-bit error
// injection at codeword position err_pos_i (1..15, 0 = none).
module hamming_encode
    import hamming_pkg::*;
(
    input  data_t data_i,
    input  pos_t  err_pos_i,
    output cw_t   cw_o
);

    cw_t flip;

    // One-hot flip mask for the requested position; empty when err_pos_i is 0.
    always_comb begin
        flip = '0;
        if (err_pos_i != '0) begin
            flip[err_pos_i - 4'd1] = 1'b1;
        end
    end

    assign cw_o = encode_hamming(data_i) ^ flip;

endmodule

// File: rtl/codifica_hamming_serial.sv
// Hamming(15,11) transmit stage: 1-entry word buffer, framing FSM and
// 15-bit shifter. Frames go out one bit per clock with sof/eof markers, the
// parallel codeword of the current/last frame is held on cw_out.
module codifica_hamming_serial
    import hamming_pkg::*;
#(
    parameter int GAP       = 0,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    codifica_hamming_serial_if.slave   bus
);

    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

    // Buffer state
    cw_t       buf_q, buf_d;
    logic      buf_full_q, buf_full_d;
    logic      in_ready_q;

    // FSM / shifter state, all outputs registered
    tx_state_t         state_q;
    cw_t               shift_q;
    logic [3:0]        cnt_q;
    logic [GAP_W-1:0]  gap_cnt_q;
    logic              tx_bit_q;
    logic              tx_valid_q;
    logic              tx_sof_q;
    logic              tx_eof_q;
    cw_t               cw_out_q;

    cw_t  enc_cw;
    logic accept;
    logic load;
    logic gap_last;
    logic first_bit;
    cw_t  shift_init;
    logic next_bit;
    cw_t  shift_next;

    hamming_encode u_encode (
        .data_i    (bus.in_data),
        .err_pos_i (bus.in_err_pos),
        .cw_o      (enc_cw)
    );

    assign accept   = bus.in_valid && in_ready_q;
    assign gap_last = (gap_cnt_q == GAP_W'(GAP - 1));

    // Shifter takes the buffered word: from IDLE, at the eof edge when frames
    // run back-to-back, or on the last gap cycle.
    always_comb begin
        load = 1'b0;
        if (buf_full_q) begin
            case (state_q)
                ST_IDLE:  load = 1'b1;
                ST_SHIFT: load = (GAP == 0) && (cnt_q == 4'd14);
                ST_GAP:   load = gap_last;
                default:  load = 1'b0;
            endcase
        end
    end

    // Bit order selection for the first bit and the following shifts.
    always_comb begin
        first_bit  = MSB_FIRST ? buf_q[CW_W-1] : buf_q[0];
        shift_init = MSB_FIRST ? {buf_q[CW_W-2:0], 1'b0} : {1'b0, buf_q[CW_W-1:1]};
        next_bit   = MSB_FIRST ? shift_q[CW_W-1] : shift_q[0];
        shift_next = MSB_FIRST ? {shift_q[CW_W-2:0], 1'b0} : {1'b0, shift_q[CW_W-1:1]};
    end

    // Buffer next state; accept and load never coincide since accept needs an empty buffer.
    always_comb begin
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        if (accept) begin
            buf_d      = enc_cw;
            buf_full_d = 1'b1;
        end else if (load) begin
            buf_full_d = 1'b0;
        end
    end

    // Holding buffer and the registered ready flag derived from its next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            in_ready_q <= !buf_full_d;
        end
    end

    // Framing FSM with shifter, counters and registered serial outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            cnt_q      <= '0;
            gap_cnt_q  <= '0;
            tx_bit_q   <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_sof_q   <= 1'b0;
            tx_eof_q   <= 1'b0;
            cw_out_q   <= '0;
        end else if (load) begin
            state_q    <= ST_SHIFT;
            shift_q    <= shift_init;
            cnt_q      <= '0;
            gap_cnt_q  <= '0;
            tx_bit_q   <= first_bit;
            tx_valid_q <= 1'b1;
            tx_sof_q   <= 1'b1;
            tx_eof_q   <= 1'b0;
            cw_out_q   <= buf_q;
        end else begin
            case (state_q)
                ST_SHIFT: begin
                    if (cnt_q == 4'd14) begin
                        state_q    <= (GAP > 0) ? ST_GAP : ST_IDLE;
                        gap_cnt_q  <= '0;
                        tx_bit_q   <= 1'b0;
                        tx_valid_q <= 1'b0;
                        tx_sof_q   <= 1'b0;
                        tx_eof_q   <= 1'b0;
                    end else begin
                        cnt_q    <= cnt_q + 4'd1;
                        shift_q  <= shift_next;
                        tx_bit_q <= next_bit;
                        tx_sof_q <= 1'b0;
                        tx_eof_q <= (cnt_q == 4'd13);
                    end
                end
                ST_GAP: begin
                    if (gap_last) begin
                        state_q <= ST_IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + GAP_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.tx_bit    = tx_bit_q;
    assign bus.tx_valid  = tx_valid_q;
    assign bus.tx_sof    = tx_sof_q;
    assign bus.tx_eof    = tx_eof_q;
    assign bus.cw_out    = cw_out_q;
    assign bus.busy      = buf_full_q || (state_q != ST_IDLE);
    assign bus.dbg_state = state_q;

endmodule
